// File: rtl/multi_adder_pkg.sv
// multi_adder_pkg
// Shared definitions for the multi_adder functional unit: mode encodings,
// FSM state encoding and the internal sum width helper.
package multi_adder_pkg;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_SAT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Width that holds the signed sum of n_in sign-extended, optionally
    // negated data_w-bit words without overflow.
    function automatic int sum_w(input int data_w, input int n_in);
        return data_w + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/multi_adder_if.sv
// multi_adder_if
// Control, configuration and data bundle of the multi_adder unit.
//   run        one-cycle start pulse
//   done       high when idle/finished
//   in_flat    N_IN input words, channel k at [k*DATA_W +: DATA_W]
//   sign_mask  bit k=1 subtracts channel k
//   mode       00 wrap, 01 accumulate per period, 10 saturate, 11 as 00
//   iter, per  number of periods / samples per period
//   delay0     cycles from run to first sample
//   out0       registered result, out_valid its qualifier
// master: the side that starts runs and feeds data; slave: the adder.
interface multi_adder_if #(
    parameter int DATA_W  = 32,
    parameter int N_IN    = 4,
    parameter int CNT_W   = 10,
    parameter int DELAY_W = 10
);
    logic                     run;
    logic                     done;
    logic [N_IN*DATA_W-1:0]   in_flat;
    logic [N_IN-1:0]          sign_mask;
    logic [1:0]               mode;
    logic [CNT_W-1:0]         iter;
    logic [CNT_W-1:0]         per;
    logic [DELAY_W-1:0]       delay0;
    logic [DATA_W-1:0]        out0;
    logic                     out_valid;

    modport master (
        output run, in_flat, sign_mask, mode, iter, per, delay0,
        input  done, out0, out_valid
    );

    modport slave (
        input  run, in_flat, sign_mask, mode, iter, per, delay0,
        output done, out0, out_valid
    );
endinterface

// File: rtl/multi_adder_sum.sv
// multi_adder_sum
// Combinational signed reduction of N_IN channels.
//   in_flat    N_IN words of DATA_W bits
//   sign_mask  bit k=1 subtracts channel k, 0 adds it
//   sum_wrap   full sum truncated to DATA_W (two's complement wrap)
//   sum_sat    full sum clamped to the signed DATA_W range
module multi_adder_sum #(
    parameter int DATA_W = 32,
    parameter int N_IN   = 4
) (
    input  logic [N_IN*DATA_W-1:0] in_flat,
    input  logic [N_IN-1:0]        sign_mask,
    output logic [DATA_W-1:0]      sum_wrap,
    output logic [DATA_W-1:0]      sum_sat
);
    import multi_adder_pkg::*;

    localparam int SUM_W = sum_w(DATA_W, N_IN);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        signed'({{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        signed'({{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

    function automatic logic [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
    endfunction

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] term;
    logic        [DATA_W-1:0] word;

    always_comb begin
        sum  = '0;
        term = '0;
        word = '0;
        for (int k = 0; k < N_IN; k++) begin
            word = in_flat[k*DATA_W +: DATA_W];
            term = signed'({{(SUM_W-DATA_W){word[DATA_W-1]}}, word});
            sum  = sign_mask[k] ? (sum - term) : (sum + term);
        end
    end

    assign sum_wrap = sum[DATA_W-1:0];
    assign sum_sat  = saturate(sum);

endmodule

// File: rtl/multi_adder.sv
// multi_adder
// N_IN-input add/subtract functional unit with run/done control, a start
// delay and wrap / per-period accumulate / saturate modes.
//   clk   clock
//   rst   asynchronous reset, active-low
//   bus   multi_adder_if slave (run/done, data, configuration, out0/out_valid)
// A sample of in_flat taken in cycle t shows on out0 in cycle t+1.
module multi_adder #(
    parameter int DATA_W  = 32,
    parameter int N_IN    = 4,
    parameter int CNT_W   = 10,
    parameter int DELAY_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    multi_adder_if.slave  bus
);
    import multi_adder_pkg::*;

    state_t               state;
    logic [CNT_W-1:0]     iter_r, per_r, per_cnt, iter_cnt;
    logic [DELAY_W-1:0]   dly_cnt;
    logic [1:0]           mode_r;
    logic [N_IN-1:0]      mask_r;
    logic [DATA_W-1:0]    acc, out0_r;
    logic                 out_valid_r, done_r;

    logic                 start, sample, first_per, last_per, last_all;
    logic [1:0]           mode_e;
    logic [N_IN-1:0]      mask_e;
    logic [CNT_W-1:0]     iter_e, per_e;
    logic [DATA_W-1:0]    sum_wrap, sum_sat, acc_next;

    assign start = (state == IDLE) && bus.run && (bus.iter != '0) && (bus.per != '0);

    // With no delay the run cycle itself is the first sample, before the
    // configuration registers are loaded, so the live inputs are used then.
    always_comb begin
        mode_e    = (state == IDLE) ? bus.mode      : mode_r;
        mask_e    = (state == IDLE) ? bus.sign_mask : mask_r;
        iter_e    = (state == IDLE) ? bus.iter      : iter_r;
        per_e     = (state == IDLE) ? bus.per       : per_r;
        sample    = (start && (bus.delay0 == '0)) ||
                    ((state == DELAY) && (dly_cnt == '0)) ||
                    (state == RUN);
        first_per = (per_cnt == '0);
        last_per  = (per_cnt == per_e - CNT_W'(1));
        last_all  = last_per && (iter_cnt == iter_e - CNT_W'(1));
        acc_next  = (first_per ? '0 : acc) + sum_wrap;
    end

    multi_adder_sum #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN)
    ) u_sum (
        .in_flat   (bus.in_flat),
        .sign_mask (mask_e),
        .sum_wrap  (sum_wrap),
        .sum_sat   (sum_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            done_r      <= 1'b1;
            out0_r      <= '0;
            out_valid_r <= 1'b0;
            acc         <= '0;
            per_cnt     <= '0;
            iter_cnt    <= '0;
            dly_cnt     <= '0;
            iter_r      <= '0;
            per_r       <= '0;
            mode_r      <= MODE_WRAP;
            mask_r      <= '0;
        end else begin
            out_valid_r <= 1'b0;

            if (start) begin
                iter_r <= bus.iter;
                per_r  <= bus.per;
                mode_r <= bus.mode;
                mask_r <= bus.sign_mask;
                if (bus.delay0 != '0) begin
                    // The last DELAY cycle (dly_cnt==0) is also the first sample.
                    state   <= DELAY;
                    dly_cnt <= bus.delay0 - DELAY_W'(1);
                    done_r  <= 1'b0;
                end
            end

            if ((state == DELAY) && (dly_cnt != '0))
                dly_cnt <= dly_cnt - DELAY_W'(1);

            if (sample) begin
                acc         <= acc_next;
                out_valid_r <= (mode_e == MODE_ACC) ? last_per : 1'b1;
                case (mode_e)
                    MODE_ACC: out0_r <= acc_next;
                    MODE_SAT: out0_r <= sum_sat;
                    default:  out0_r <= sum_wrap;
                endcase
                if (last_all) begin
                    state    <= IDLE;
                    done_r   <= 1'b1;
                    per_cnt  <= '0;
                    iter_cnt <= '0;
                end else begin
                    state   <= RUN;
                    done_r  <= 1'b0;
                    per_cnt <= last_per ? '0 : per_cnt + CNT_W'(1);
                    if (last_per)
                        iter_cnt <= iter_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out0      = out0_r;
    assign bus.out_valid = out_valid_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_multi_adder.sv
// tb_multi_adder
// Scoreboard bench for multi_adder: each driven cycle pushes the expected
// out0/out_valid/done for the following cycle; they are popped and compared
// one time unit after the next rising edge.
module tb_multi_adder;
    localparam int DATA_W  = 32;
    localparam int N_IN    = 4;
    localparam int CNT_W   = 10;
    localparam int DELAY_W = 10;

    localparam logic [1:0] M_WRAP = 2'b00;
    localparam logic [1:0] M_ACC  = 2'b01;
    localparam logic [1:0] M_SAT  = 2'b10;
    localparam logic [1:0] M_RSV  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_adder_if #(.DATA_W(DATA_W), .N_IN(N_IN), .CNT_W(CNT_W), .DELAY_W(DELAY_W)) bus ();

    multi_adder #(.DATA_W(DATA_W), .N_IN(N_IN), .CNT_W(CNT_W), .DELAY_W(DELAY_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DATA_W-1:0] out0;
        logic              out_valid;
        logic              done;
    } exp_t;

    exp_t              sb_q[$];
    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] exp_out  = '0;
    logic [DATA_W-1:0] acc_m    = '0;
    logic [DATA_W-1:0] fixed_in [N_IN];

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_sat(input longint s);
        if (s > 64'sh7FFF_FFFF)
            return 32'h7FFF_FFFF;
        else if (s < -64'sh8000_0000)
            return 32'h8000_0000;
        else
            return s[DATA_W-1:0];
    endfunction

    // One complete operation: run in cycle 0, samples at cycles d..d+n-1.
    task automatic do_op(input string name, input int d, input int it, input int pr,
                         input logic [1:0] md, input logic [N_IN-1:0] mask,
                         input bit rnd, input int busy_at);
        int     n;
        int     idx;
        int     pidx;
        longint s;
        logic [DATA_W-1:0] w;
        exp_t   e;
        n = it * pr;
        for (int k = 0; k < d + n + 3; k++) begin
            bus.run = (k == 0) || (k == busy_at);
            if (k == 0) begin
                bus.mode      = md;
                bus.sign_mask = mask;
                bus.iter      = CNT_W'(it);
                bus.per       = CNT_W'(pr);
                bus.delay0    = DELAY_W'(d);
            end else begin
                bus.mode      = 2'($urandom());
                bus.sign_mask = N_IN'($urandom());
                bus.iter      = CNT_W'($urandom());
                bus.per       = CNT_W'($urandom());
                bus.delay0    = DELAY_W'($urandom());
            end
            s = 0;
            for (int ch = 0; ch < N_IN; ch++) begin
                w = rnd ? DATA_W'($urandom()) : fixed_in[ch];
                bus.in_flat[ch*DATA_W +: DATA_W] = w;
                s = mask[ch] ? s - longint'(int'(w)) : s + longint'(int'(w));
            end
            e.out_valid = 1'b0;
            if (n > 0 && k >= d && k < d + n) begin
                idx   = k - d;
                pidx  = idx % pr;
                acc_m = ((pidx == 0) ? '0 : acc_m) + s[DATA_W-1:0];
                if (md == M_ACC) begin
                    exp_out     = acc_m;
                    e.out_valid = (pidx == pr - 1);
                end else begin
                    exp_out     = (md == M_SAT) ? model_sat(s) : s[DATA_W-1:0];
                    e.out_valid = 1'b1;
                end
            end
            e.out0 = exp_out;
            e.done = (n == 0) || (k >= d + n - 1);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s k%0d scoreboard empty", name, k);
            end else begin
                e = sb_q.pop_front();
                check_val($sformatf("%s k%0d out0", name, k), bus.out0, e.out0);
                check_val($sformatf("%s k%0d out_valid", name, k), DATA_W'(bus.out_valid), DATA_W'(e.out_valid));
                check_val($sformatf("%s k%0d done", name, k), DATA_W'(bus.done), DATA_W'(e.done));
            end
        end
        bus.run = 1'b0;
    endtask

    task automatic set_fixed(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        fixed_in[0] = a;
        fixed_in[1] = b;
        fixed_in[2] = c;
        fixed_in[3] = d;
    endtask

    initial begin
        rst           = 1'b0;
        bus.run       = 1'b0;
        bus.in_flat   = '0;
        bus.sign_mask = '0;
        bus.mode      = M_WRAP;
        bus.iter      = '0;
        bus.per       = '0;
        bus.delay0    = '0;
        set_fixed(0, 0, 0, 0);
        #12;
        check_val("reset out0", bus.out0, '0);
        check_val("reset out_valid", DATA_W'(bus.out_valid), '0);
        check_val("reset done", DATA_W'(bus.done), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        set_fixed(1, 2, 3, 4);
        do_op("basic", 0, 1, 3, M_WRAP, 4'b0000, 1'b0, -1);

        set_fixed(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1);
        do_op("sat_pos", 0, 1, 1, M_SAT, 4'b1000, 1'b0, -1);
        do_op("wrap_pos", 0, 1, 1, M_WRAP, 4'b1000, 1'b0, -1);
        set_fixed(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        do_op("sat_neg", 0, 1, 2, M_SAT, 4'b0000, 1'b0, -1);

        set_fixed(1, 0, 0, 0);
        do_op("acc", 0, 2, 4, M_ACC, 4'b0000, 1'b0, -1);

        do_op("delay5", 5, 1, 1, M_WRAP, 4'b0101, 1'b1, -1);
        do_op("iter0", 0, 0, 4, M_WRAP, 4'b0000, 1'b1, -1);
        do_op("per0", 3, 2, 0, M_SAT, 4'b0000, 1'b1, -1);

        do_op("rand_sat", 2, 2, 3, M_SAT, 4'b0110, 1'b1, -1);
        do_op("rand_acc", 1, 3, 2, M_ACC, 4'b1001, 1'b1, -1);
        do_op("rand_rsv", 0, 1, 4, M_RSV, 4'b0011, 1'b1, -1);
        do_op("busy", 1, 2, 3, M_WRAP, 4'b0010, 1'b1, 3);

        // Abort a long run with an asynchronous reset between clock edges.
        bus.run       = 1'b1;
        bus.mode      = M_WRAP;
        bus.sign_mask = '0;
        bus.iter      = CNT_W'(3);
        bus.per       = CNT_W'(10);
        bus.delay0    = '0;
        bus.in_flat   = {32'd4, 32'd3, 32'd2, 32'd1};
        @(posedge clk);
        #1;
        bus.run = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check_val("midrun busy", DATA_W'(bus.done), '0);
        rst = 1'b0;
        #1;
        check_val("midrun rst out0", bus.out0, '0);
        check_val("midrun rst out_valid", DATA_W'(bus.out_valid), '0);
        check_val("midrun rst done", DATA_W'(bus.done), 32'd1);
        exp_out = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op("after_rst", 0, 3, 10, M_WRAP, 4'b0100, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
